ahb_bridge_arbiter: RTL and testbench
=====================================

Name: ahb_bridge_arbiter

Overview:
- Shares the single AHB slave port of the AHB-to-APB bridge (Bridge_Top) between NUM_REQ local requesters using round-robin arbitration.
- Sequences each granted request as one AHB SINGLE word transfer: address phase, then data phase. Stalls on Hreadyout.
- Returns read data, error status and a one-cycle done pulse to the winning requester.
- Sits between on-chip requesters and the bridge AHB pins, in the Hclk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT_CYCLES, 64, data-phase watchdog limit (used only with the optional feature).

Ports:
- Hclk  in  1  AHB clock; all logic is on the rising edge.
- Hresetn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_addr  in  NUM_REQ*AW  packed addresses; requester i occupies [i*AW +: AW].
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_wdata  in  NUM_REQ*DW  packed write data.
- gnt  out  NUM_REQ  one-hot; high for the whole transfer of the winner.
- done  out  NUM_REQ  one-hot, one-cycle pulse at transfer completion.
- rsp_rdata  out  DW  read data; valid while done is high.
- rsp_err  out  1  error flag; valid while done is high.
- Haddr  out  AW  AHB address.
- Hwrite  out  1  AHB write.
- Htrans  out  2  AHB transfer type.
- Hsize  out  3  constant 3'b010 (word).
- Hburst  out  3  constant 3'b000 (SINGLE).
- Hwdata  out  DW  AHB write data.
- Hreadyin  out  1  constant 1.
- Hreadyout  in  1  bridge ready.
- Hrdata  in  DW  bridge read data.
- Hresp  in  2  bridge response; 2'b01 = ERROR.

Behaviour:
- Reset values (asynchronous):
  - State IDLE.
  - gnt = 0, done = 0.
  - Htrans = 2'b00, Haddr = 0, Hwrite = 0, Hwdata = 0.
  - rsp_rdata = 0, rsp_err = 0.
  - Round-robin pointer rr_ptr = 0.
- Reset asserted mid-transfer: all of the above apply immediately. The aborted requester receives no done pulse.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If req != 0, pick the first set bit at or above rr_ptr, wrapping modulo NUM_REQ.
  - Latch that requester's addr, write and wdata into registers; set gnt one-hot; go to ADDR.
  - Otherwise stay in IDLE with Htrans = IDLE.
- ADDR:
  - Drive Htrans = 2'b10 (NONSEQ), Haddr and Hwrite from the latched values.
  - If Hreadyout = 1, go to DATA; otherwise hold all outputs unchanged.
- DATA:
  - Drive Htrans = 2'b00 and Hwdata from the latched value.
  - Wait for Hreadyout = 1, then:
    - Capture Hrdata into rsp_rdata (writes capture as well; the value is don't-care).
    - Set rsp_err = (Hresp == 2'b01).
    - Pulse done[winner] for one cycle and drop gnt.
    - Set rr_ptr = (winner + 1) mod NUM_REQ; go to IDLE.
- Latency: minimum 3 Hclk from req high in IDLE to done (IDLE → ADDR → DATA, zero wait). Each Hreadyout-low cycle adds one.
- Back-to-back traffic: at least one IDLE cycle between transfers; no pipelined address phases.
- Request sampling:
  - req is sampled only in IDLE.
  - Dropping req after grant does not cancel the transfer.
  - Changing req_addr or req_wdata after grant has no effect.
- Fairness: with all requesters active, the grant order is 0, 1, …, NUM_REQ-1, 0, … A requester waits at most NUM_REQ-1 transfers.
- Wrap-around: rr_ptr = NUM_REQ-1 with only req[0] set grants requester 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in ADDR and DATA and clears on every state change.
  - When it reaches TIMEOUT_CYCLES with Hreadyout still 0, the FSM forces completion: done[winner] pulses, rsp_err = 1, rsp_rdata = 0, Htrans = IDLE, back to IDLE.
- Undefined: no counter; the FSM waits on Hreadyout indefinitely.

Decomposition:
- Package ahb_arb_pkg holds:
  - Typedef arb_state_e {IDLE, ADDR, DATA}.
  - Constants HTRANS_IDLE = 2'b00, HTRANS_NONSEQ = 2'b10, HSIZE_WORD = 3'b010, HBURST_SINGLE = 3'b000, HRESP_OKAY = 2'b00, HRESP_ERROR = 2'b01.
- Sub-module rr_pick: purely combinational round-robin priority encoder.
  - Inputs: req, rr_ptr.
  - Outputs: one-hot grant, binary index, any.

Test Plan:
- Single read: req[2] with addr 0x0000_0010, bridge returns Hrdata 0xDEAD_BEEF, zero wait → gnt[2] high at the next cycle; Htrans NONSEQ for 1 cycle with Haddr 0x10 and Hwrite 0; done[2] on cycle 3 with rsp_rdata 0xDEAD_BEEF and rsp_err 0.
- Write with waits: req[0] writes 0x1234_5678 to 0x20, Hreadyout held low 4 cycles in DATA → Hwdata stable at 0x1234_5678 throughout; done[0] on cycle 7.
- Fairness: req = 4'b1111 held → grants 0, 1, 2, 3, 0 in that order; next start always one IDLE cycle after done.
- Error and wrap: rr_ptr = 3, req = 4'b0001, Hresp = 01 in DATA → gnt[0]; done[0] with rsp_err 1.
- Reset mid-DATA: Hresetn low while gnt[1] → gnt 0, done 0, Htrans 00 immediately; no done[1] after release.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): Hreadyout stuck at 0 → done pulse with rsp_err 1 and rsp_rdata 0 exactly 8 cycles after entering DATA.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: shared state encoding and AHB encodings for the bridge arbiter
package ahb_arb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_e;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
endpackage

// File: rtl/ahb_bridge_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder, first set bit at or above ptr
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
    gnt[idx] = any;
  end
endmodule

// File: rtl/ahb_bridge_arbiter.sv
// ahb_bridge_arbiter: round-robin share of one AHB slave port, one SINGLE word per grant.
// Optional data-phase watchdog enabled by defining ARB_TIMEOUT_EN.
module ahb_bridge_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic [AW-1:0]         Haddr,
  output logic                  Hwrite,
  output logic [1:0]            Htrans,
  output logic [2:0]            Hsize,
  output logic [2:0]            Hburst,
  output logic [DW-1:0]         Hwdata,
  output logic                  Hreadyin,
  input  logic                  Hreadyout,
  input  logic [DW-1:0]         Hrdata,
  input  logic [1:0]            Hresp
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_e state;
  logic [IW-1:0] rr_ptr, win, pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic pick_any, expired;
  logic [DW-1:0] wdata_q;
  assign Hsize    = HSIZE_WORD;
  assign Hburst   = HBURST_SINGLE;
  assign Hreadyin = 1'b1;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // cnt counts completed wait cycles; it restarts whenever the state changes
  assign expired = (state != IDLE) && !Hreadyout && (cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge Hclk or negedge Hresetn)
    if (!Hresetn) cnt <= '0;
    else cnt <= (state == IDLE || Hreadyout || expired) ? '0 : cnt + CW'(1);
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= '0;
      win       <= '0;
      rr_ptr    <= '0;
      Htrans    <= HTRANS_IDLE;
      Haddr     <= '0;
      Hwrite    <= 1'b0;
      Hwdata    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: if (pick_any) begin
          state   <= ADDR;
          gnt     <= pick_gnt;
          win     <= pick_idx;
          Htrans  <= HTRANS_NONSEQ;
          Haddr   <= req_addr[pick_idx*AW +: AW];
          Hwrite  <= req_write[pick_idx];
          wdata_q <= req_wdata[pick_idx*DW +: DW];
        end
        ADDR: if (Hreadyout) begin
          state  <= DATA;
          Htrans <= HTRANS_IDLE;
          Hwdata <= wdata_q;
        end
        DATA: ;
        default: state <= IDLE;
      endcase
      if ((state == DATA && Hreadyout) || expired) begin
        state     <= IDLE;
        Htrans    <= HTRANS_IDLE;
        done      <= gnt;
        gnt       <= '0;
        rsp_rdata <= expired ? '0 : Hrdata;
        rsp_err   <= expired || (Hresp == HRESP_ERROR);
        rr_ptr    <= (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// tb_ahb_bridge_arbiter: randomized and directed transfers checked against a transaction-level model
module tb_ahb_bridge_arbiter;
  logic Hclk = 1'b0, Hresetn = 1'b0;
  logic [3:0] req = '0, req_write = '0, gnt, done;
  logic [127:0] req_addr = '0, req_wdata = '0;
  logic [31:0] rsp_rdata, Haddr, Hwdata, Hrdata = '0;
  logic rsp_err, Hwrite, Hreadyin, Hreadyout = 1'b1;
  logic [1:0] Htrans, Hresp = 2'b00;
  logic [2:0] Hsize, Hburst;
  int total = 0, bad = 0, ptr = 0;

  ahb_bridge_arbiter #(.NUM_REQ(4), .AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .req(req), .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Haddr(Haddr), .Hwrite(Hwrite), .Htrans(Htrans), .Hsize(Hsize), .Hburst(Hburst),
    .Hwdata(Hwdata), .Hreadyin(Hreadyin), .Hreadyout(Hreadyout), .Hrdata(Hrdata), .Hresp(Hresp)
  );

  always #5 Hclk = ~Hclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one full transfer; called on a negedge while the arbiter is idle
  task automatic xfer(input logic [3:0] r, input int aw, input int dw,
                      input logic [1:0] resp, input logic [31:0] rd);
    int w = 0;
    bit found = 0;
    logic [3:0] eg;
    logic [31:0] a, d;
    logic wr;
    for (int k = 0; k < 4; k++)
      if (!found && r[(ptr + k) % 4]) begin
        w = (ptr + k) % 4;
        found = 1;
      end
    eg = 4'b0001 << w;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32] = $urandom;
      req_wdata[i*32 +: 32] = $urandom;
    end
    req_write = 4'($urandom);
    a = req_addr[w*32 +: 32];
    d = req_wdata[w*32 +: 32];
    wr = req_write[w];
    req = r;
    Hreadyout = 1'b1;
    @(negedge Hclk);
    check("gnt_addr", gnt, eg);
    check("htrans_nonseq", Htrans, 2'b10);
    check("haddr", Haddr, a);
    check("hwrite", Hwrite, wr);
    check("done_addr", done, 0);
    req = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32] = $urandom;
      req_wdata[i*32 +: 32] = $urandom;
    end
    req_write = 4'($urandom);
    Hreadyout = (aw == 0);
    for (int i = 0; i < aw; i++) begin
      @(negedge Hclk);
      check("addr_wait_trans", Htrans, 2'b10);
      check("addr_wait_haddr", Haddr, a);
      Hreadyout = (i == aw - 1);
    end
    @(negedge Hclk);
    check("htrans_data", Htrans, 2'b00);
    check("hwdata", Hwdata, d);
    check("gnt_data", gnt, eg);
    Hrdata = rd;
    Hresp = resp;
    Hreadyout = (dw == 0);
    for (int i = 0; i < dw; i++) begin
      @(negedge Hclk);
      check("data_wait_done", done, 0);
      check("data_wait_hwdata", Hwdata, d);
      Hreadyout = (i == dw - 1);
    end
    @(negedge Hclk);
    check("done", done, eg);
    check("rsp_rdata", rsp_rdata, rd);
    check("rsp_err", rsp_err, resp == 2'b01);
    check("gnt_released", gnt, 0);
    ptr = (w + 1) % 4;
    req = '0;
    Hreadyout = 1'b1;
    Hresp = 2'b00;
  endtask

  initial begin
    #2;
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_htrans", Htrans, 0);
    check("rst_haddr", Haddr, 0);
    check("rst_hwdata", Hwdata, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_consts", {Hsize, Hburst, Hreadyin}, 7'b010_000_1);
    @(negedge Hclk);
    Hresetn = 1'b1;
    @(negedge Hclk);
    for (int i = 0; i < 5; i++) xfer(4'b1111, 0, 0, 2'b00, $urandom);
    xfer(4'b0100, 0, 0, 2'b00, 32'hDEAD_BEEF);
    xfer(4'b0001, 0, 4, 2'b00, $urandom);
    xfer(4'b0100, 0, 0, 2'b00, $urandom);
    check("ptr_is_3", ptr, 3);
    xfer(4'b0001, 0, 0, 2'b01, $urandom);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(1, 15));
      xfer(r, $urandom_range(0, 3), $urandom_range(0, 3), ($urandom & 1) ? 2'b01 : 2'b00, $urandom);
    end
    req = 4'b0010;
    @(negedge Hclk);
    check("rst_mid_gnt1", gnt, 4'b0010);
    req = '0;
    @(negedge Hclk);
    Hreadyout = 1'b0;
    Hresetn = 1'b0;
    #1;
    check("rst_mid_gnt", gnt, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_htrans", Htrans, 0);
    @(negedge Hclk);
    Hresetn = 1'b1;
    Hreadyout = 1'b1;
    ptr = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Hclk);
      check("no_done_after_rst", done, 0);
    end
    xfer(4'b1010, 1, 2, 2'b00, $urandom);
`ifdef ARB_TIMEOUT_EN
    begin
      int n = 0;
      req = 4'b0001;
      @(negedge Hclk);
      req = '0;
      Hrdata = 32'hFFFF_FFFF;
      @(negedge Hclk);
      Hreadyout = 1'b0;
      while (done == 0 && n < 20) begin
        @(negedge Hclk);
        n++;
      end
      check("timeout_cycles", n, 8);
      check("timeout_done", done, 4'b0001);
      check("timeout_err", rsp_err, 1);
      check("timeout_rdata", rsp_rdata, 0);
      Hreadyout = 1'b1;
      @(negedge Hclk);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
